// File: rtl/mux_nto1_reg.sv
// mux_nto1_reg
//   Parametrised N-to-1 datapath selector with a registered output.
//   Operating modes:
//     DIRECT - selects the input given by sel.
//     SCAN   - an internal index walks inputs 0..NUM_IN-1 and then wraps.
//     HOLD   - freezes the output.
//   An illegal sel, or the reserved mode, is flagged on sel_err.
//   All outputs come from registers, so there is no combinational path
//   from any input to any output.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset (release is synchronous to clk)
//   in_bus     flattened inputs; input k = in_bus[k*WIDTH +: WIDTH]
//   sel        input index, used in DIRECT mode
//   mode       00 DIRECT, 01 SCAN, 10 HOLD, 11 reserved (behaves as HOLD, flags error)
//   en         capture enable; when 0, all state holds
//   out        registered selected data
//   out_valid  one-cycle pulse: out was loaded on this edge
//   sel_q      index of the input currently held in out
//   sel_err    illegal sel or reserved mode on the last enabled cycle
module mux_nto1_reg #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic [1:0]              mode,
  input  logic                    en,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        sel_q,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  // The scan index wraps at NUM_IN, not at 2^SEL_W.
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_IN - 1);

  logic [WIDTH-1:0] in_arr [NUM_IN];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign in_arr[gi] = in_bus[gi*WIDTH +: WIDTH];
    end
  endgenerate

  mode_t            mode_in;
  logic             sel_ok;
  logic [WIDTH-1:0] direct_data;
  logic [WIDTH-1:0] scan_data;

  logic [WIDTH-1:0] out_reg,   out_next;
  logic             valid_reg, valid_next;
  logic [SEL_W-1:0] sel_q_reg, sel_q_next;
  logic             err_reg,   err_next;
  logic [SEL_W-1:0] idx_reg,   idx_next;

  assign mode_in = mode_t'(mode);
  assign sel_ok  = (int'(sel) < NUM_IN);

  // The two read ports are built as compare-and-select loops. This keeps
  // an out-of-range sel from indexing past the array when NUM_IN is not a
  // power of two; such a sel simply yields zero, and that value is never
  // captured.
  always_comb begin
    direct_data = '0;
    scan_data   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        direct_data = in_arr[k];
      end
      if (idx_reg == SEL_W'(k)) begin
        scan_data = in_arr[k];
      end
    end
  end

  always_comb begin
    out_next   = out_reg;
    sel_q_next = sel_q_reg;
    idx_next   = idx_reg;
    err_next   = err_reg;
    valid_next = 1'b0;
    if (en) begin
      // Any enabled non-SCAN edge rearms the scan at input 0.
      idx_next = '0;
      err_next = 1'b0;
      case (mode_in)
        MODE_DIRECT: begin
          if (sel_ok) begin
            out_next   = direct_data;
            sel_q_next = sel;
            valid_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
        MODE_SCAN: begin
          out_next   = scan_data;
          sel_q_next = idx_reg;
          valid_next = 1'b1;
          idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
        MODE_HOLD: begin
        end
        MODE_RSVD: begin
          err_next = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg   <= '0;
      valid_reg <= 1'b0;
      sel_q_reg <= '0;
      err_reg   <= 1'b0;
      idx_reg   <= '0;
    end else begin
      out_reg   <= out_next;
      valid_reg <= valid_next;
      sel_q_reg <= sel_q_next;
      err_reg   <= err_next;
      idx_reg   <= idx_next;
    end
  end

  assign out       = out_reg;
  assign out_valid = valid_reg;
  assign sel_q     = sel_q_reg;
  assign sel_err   = err_reg;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// tb_mux_nto1_reg
//   Bench for mux_nto1_reg. It drives two instances in parallel: one with
//   8 inputs and one with 5. Both share clk, reset, sel, mode and en. The
//   input words come from a common table, and the 5-input instance sees
//   the first five words.
module tb_mux_nto1_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  sel;
  logic [1:0]  mode;
  logic        en;
  logic [31:0] din [8];

  logic [8*32-1:0] in_bus8;
  logic [5*32-1:0] in_bus5;

  logic [31:0] out8,   out5;
  logic        valid8, valid5;
  logic [2:0]  selq8,  selq5;
  logic        err8,   err5;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bus8
      assign in_bus8[gi*32 +: 32] = din[gi];
    end
    for (gi = 0; gi < 5; gi++) begin : g_bus5
      assign in_bus5[gi*32 +: 32] = din[gi];
    end
  endgenerate

  mux_nto1_reg #(.WIDTH(32), .NUM_IN(8)) u8 (
    .clk(clk), .reset(reset), .in_bus(in_bus8), .sel(sel), .mode(mode), .en(en),
    .out(out8), .out_valid(valid8), .sel_q(selq8), .sel_err(err8)
  );

  mux_nto1_reg #(.WIDTH(32), .NUM_IN(5)) u5 (
    .clk(clk), .reset(reset), .in_bus(in_bus5), .sel(sel), .mode(mode), .en(en),
    .out(out5), .out_valid(valid5), .sel_q(selq5), .sel_err(err5)
  );

  always #5 clk = ~clk;

  // Observed outputs, indexed by instance: 0 = 8 inputs, 1 = 5 inputs.
  logic [31:0] o_out   [2];
  logic        o_valid [2];
  logic [2:0]  o_selq  [2];
  logic        o_err   [2];
  assign o_out[0]   = out8;   assign o_out[1]   = out5;
  assign o_valid[0] = valid8; assign o_valid[1] = valid5;
  assign o_selq[0]  = selq8;  assign o_selq[1]  = selq5;
  assign o_err[0]   = err8;   assign o_err[1]   = err5;

  // Reference model state per instance.
  logic [31:0] m_out   [2];
  logic        m_valid [2];
  logic [2:0]  m_selq  [2];
  logic        m_err   [2];
  int          m_idx   [2];

  int n_vec = 0;
  int n_err = 0;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 32'h0; m_valid[i] = 1'b0; m_selq[i] = 3'd0;
      m_err[i] = 1'b0;  m_idx[i] = 0;
    end
  endtask

  // Applies the rules for one clock edge to each instance, using the
  // inputs the bench is currently driving.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int n;
      n = (i == 0) ? 8 : 5;
      if (reset) begin
        m_out[i] = 32'h0; m_valid[i] = 1'b0; m_selq[i] = 3'd0;
        m_err[i] = 1'b0;  m_idx[i] = 0;
      end else if (!en) begin
        m_valid[i] = 1'b0;
      end else begin
        case (mode)
          2'b00: begin
            if (int'(sel) < n) begin
              m_out[i] = din[sel]; m_selq[i] = sel; m_valid[i] = 1'b1; m_err[i] = 1'b0;
            end else begin
              m_valid[i] = 1'b0; m_err[i] = 1'b1;
            end
            m_idx[i] = 0;
          end
          2'b01: begin
            m_out[i] = din[m_idx[i]]; m_selq[i] = 3'(m_idx[i]);
            m_valid[i] = 1'b1; m_err[i] = 1'b0;
            m_idx[i] = (m_idx[i] + 1) % n;
          end
          2'b10: begin
            m_valid[i] = 1'b0; m_err[i] = 1'b0; m_idx[i] = 0;
          end
          default: begin
            m_valid[i] = 1'b0; m_err[i] = 1'b1; m_idx[i] = 0;
          end
        endcase
      end
    end
  endtask

  // Advances one clock edge, then updates the model from the inputs that
  // were sampled on that edge. Outputs are read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; mode = 2'b00; sel = 3'd0;
    for (int k = 0; k < 8; k++) din[k] = 32'h1000 + k;
    model_reset();
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({o_out[i], o_valid[i], o_selq[i], o_err[i]} !== 37'h0) begin
        n_err++;
        $display("FAIL reset[%0d] out=%h valid=%b sel_q=%0d err=%b required all zero",
                 i, o_out[i], o_valid[i], o_selq[i], o_err[i]);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_direct();
    mode = 2'b00; en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      tick();
      n_vec++;
      if ({out8, valid8, selq8, err8} !== {32'h1000 + 32'(s), 1'b1, 3'(s), 1'b0}) begin
        n_err++;
        $display("FAIL direct8 sel=%0d got out=%h v=%b q=%0d e=%b required out=%h v=1 q=%0d e=0",
                 s, out8, valid8, selq8, err8, 32'h1000 + 32'(s), s);
      end
      n_vec++;
      if ({out5, valid5, selq5, err5} !== {m_out[1], m_valid[1], m_selq[1], m_err[1]}) begin
        n_err++;
        $display("FAIL direct5 sel=%0d got out=%h v=%b q=%0d e=%b required out=%h v=%b q=%0d e=%b",
                 s, out5, valid5, selq5, err5, m_out[1], m_valid[1], m_selq[1], m_err[1]);
      end
    end
  endtask

  task automatic test_sel_err();
    mode = 2'b00; en = 1'b1;
    sel = 3'd2; tick();
    sel = 3'd6; tick();
    n_vec++;
    if ({out5, valid5, selq5, err5} !== {din[2], 1'b0, 3'd2, 1'b1}) begin
      n_err++;
      $display("FAIL sel_err5 got out=%h v=%b q=%0d e=%b required out=%h v=0 q=2 e=1",
               out5, valid5, selq5, err5, din[2]);
    end
    n_vec++;
    if ({out8, valid8, selq8, err8} !== {din[6], 1'b1, 3'd6, 1'b0}) begin
      n_err++;
      $display("FAIL sel6_8 got out=%h v=%b q=%0d e=%b required out=%h v=1 q=6 e=0",
               out8, valid8, selq8, err8, din[6]);
    end
    sel = 3'd1; tick();
    n_vec++;
    if ({out5, valid5, selq5, err5} !== {din[1], 1'b1, 3'd1, 1'b0}) begin
      n_err++;
      $display("FAIL sel_recover5 got out=%h v=%b q=%0d e=%b required out=%h v=1 q=1 e=0",
               out5, valid5, selq5, err5, din[1]);
    end
  endtask

  task automatic test_scan();
    int seq [7] = '{0, 1, 2, 3, 4, 0, 1};
    mode = 2'b00; sel = 3'd0; en = 1'b1; tick();
    mode = 2'b01;
    for (int e = 0; e < 7; e++) begin
      tick();
      n_vec++;
      if ({out5, valid5, selq5} !== {din[seq[e]], 1'b1, 3'(seq[e])}) begin
        n_err++;
        $display("FAIL scan5 step=%0d got out=%h v=%b q=%0d required out=%h v=1 q=%0d",
                 e, out5, valid5, selq5, din[seq[e]], seq[e]);
      end
      n_vec++;
      if ({out8, selq8} !== {din[e], 3'(e)}) begin
        n_err++;
        $display("FAIL scan8 step=%0d got out=%h q=%0d required out=%h q=%0d",
                 e, out8, selq8, din[e], e);
      end
    end
    en = 1'b0;
    for (int p = 0; p < 2; p++) begin
      tick();
      n_vec++;
      if ({valid5, selq5, out5} !== {1'b0, 3'd1, din[1]}) begin
        n_err++;
        $display("FAIL scan_pause5 cyc=%0d got v=%b q=%0d out=%h required v=0 q=1 out=%h",
                 p, valid5, selq5, out5, din[1]);
      end
    end
    en = 1'b1; tick();
    n_vec++;
    if ({valid5, selq5, out5} !== {1'b1, 3'd2, din[2]}) begin
      n_err++;
      $display("FAIL scan_resume5 got v=%b q=%0d out=%h required v=1 q=2 out=%h",
               valid5, selq5, out5, din[2]);
    end
    n_vec++;
    if ({valid8, selq8, out8} !== {1'b1, 3'd7, din[7]}) begin
      n_err++;
      $display("FAIL scan_resume8 got v=%b q=%0d out=%h required v=1 q=7 out=%h",
               valid8, selq8, out8, din[7]);
    end
  endtask

  task automatic test_hold();
    en = 1'b1; mode = 2'b00; sel = 3'd4; tick();
    mode = 2'b01; tick(); tick(); tick();
    mode = 2'b10; tick();
    n_vec++;
    if ({valid8, err8, selq8, out8} !== {1'b0, 1'b0, 3'd2, din[2]}) begin
      n_err++;
      $display("FAIL hold8 got v=%b e=%b q=%0d out=%h required v=0 e=0 q=2 out=%h",
               valid8, err8, selq8, out8, din[2]);
    end
    mode = 2'b01; tick();
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({o_out[i], o_selq[i], o_valid[i]} !== {din[0], 3'd0, 1'b1}) begin
        n_err++;
        $display("FAIL hold_rescan[%0d] got out=%h q=%0d v=%b required out=%h q=0 v=1",
                 i, o_out[i], o_selq[i], o_valid[i], din[0]);
      end
    end
    mode = 2'b11; tick();
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({o_out[i], o_err[i], o_valid[i]} !== {din[0], 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL reserved[%0d] got out=%h e=%b v=%b required out=%h e=1 v=0",
                 i, o_out[i], o_err[i], o_valid[i], din[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1; mode = 2'b01; tick(); tick(); tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({o_out[i], o_valid[i], o_selq[i], o_err[i]} !== 37'h0) begin
        n_err++;
        $display("FAIL async_reset[%0d] out=%h v=%b q=%0d e=%b required all zero",
                 i, o_out[i], o_valid[i], o_selq[i], o_err[i]);
      end
    end
    #1;
    reset = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({o_selq[i], o_out[i], o_valid[i]} !== {3'd0, din[0], 1'b1}) begin
        n_err++;
        $display("FAIL post_reset_scan[%0d] got q=%0d out=%h v=%b required q=0 out=%h v=1",
                 i, o_selq[i], o_out[i], o_valid[i], din[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 8; k++) din[k] = $urandom;
      sel   = 3'($urandom_range(0, 7));
      mode  = 2'($urandom_range(0, 9) < 5 ? 1 : $urandom_range(0, 3));
      en    = ($urandom_range(0, 4) != 0);
      reset = ($urandom_range(0, 63) == 0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if ({o_out[i], o_valid[i], o_selq[i], o_err[i]} !==
            {m_out[i], m_valid[i], m_selq[i], m_err[i]}) begin
          n_err++;
          $display("FAIL random[%0d] cyc=%0d got out=%h v=%b q=%0d e=%b required out=%h v=%b q=%0d e=%b",
                   i, c, o_out[i], o_valid[i], o_selq[i], o_err[i],
                   m_out[i], m_valid[i], m_selq[i], m_err[i]);
        end
        n_vec++;
        if ((o_valid[i] & o_err[i]) !== 1'b0) begin
          n_err++;
          $display("FAIL valid_err_excl[%0d] cyc=%0d got v=%b e=%b required not both",
                   i, c, o_valid[i], o_err[i]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b00; sel = 3'd0;
    for (int k = 0; k < 8; k++) din[k] = 32'h0;
    model_reset();
    test_reset();
    test_direct();
    test_sel_err();
    test_scan();
    test_hold();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
